// File: rtl/meminstruc_pkg.sv
// Shared definitions for the instruction-memory loader.
//   state_t        : loader FSM states
//   BYTES_PER_WORD : bytes per program word
//   be_byte()      : big-endian byte select (byte 0 is the MSB)
package meminstruc_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        StIdle,
        StWaitWord,
        StWrite,
        StDone
    } state_t;

    // Byte k of a word in memory order: k=0 -> bits [31:24], k=3 -> bits [7:0].
    function automatic logic [7:0] be_byte(input logic [31:0] w, input logic [1:0] k);
        logic [4:0] sh;
        sh = 5'd24 - {k, 3'b000};
        return 8'(w >> sh);
    endfunction

endpackage

// File: rtl/meminstruc_byte_serializer.sv
// Splits a 32-bit word into four MSB-first bytes, one per advance.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture word and present byte 0 on the next cycle
//   advance    : present the next byte on the next cycle
//   word       : word to serialise
//   byte_data  : registered current byte
//   byte_idx   : index (0..3) of the byte in byte_data
module meminstruc_byte_serializer
    import meminstruc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        advance,
    input  logic [31:0] word,
    output logic [7:0]  byte_data,
    output logic [1:0]  byte_idx
);

    logic [31:0] word_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q    <= '0;
            byte_idx  <= '0;
            byte_data <= '0;
        end else if (load) begin
            word_q    <= word;
            byte_idx  <= 2'd0;
            byte_data <= be_byte(word, 2'd0);
        end else if (advance) begin
            byte_idx  <= byte_idx + 2'd1;
            byte_data <= be_byte(word_q, byte_idx + 2'd1);
        end
    end

endmodule

// File: rtl/meminstruc_loader.sv
// Writer side of the byte-addressed instruction memory. Accepts 32-bit program
// words over a valid/ready stream and writes them big-endian, one byte per cycle.
// Optional feature macro: MEMINSTRUC_LOADER_CHECKSUM_EN adds a checksum output.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   start         : pulse that begins a session (honoured in idle/done only)
//   word_in       : program word; word_valid / word_last qualify it
//   word_ready    : loader accepts word_in this cycle
//   wr_en/addr/data : registered byte write port
//   busy          : session in progress
//   done          : session finished, held until next start
//   overflow      : memory filled before the last word was seen
//   words_written : complete words written this session
//   checksum      : (feature only) modulo-256 sum of bytes written this session
module meminstruc_loader
    import meminstruc_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 256,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       word_in,
    input  logic              word_valid,
    input  logic              word_last,
    output logic              word_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              done,
    output logic              overflow,
`ifdef MEMINSTRUC_LOADER_CHECKSUM_EN
    output logic [7:0]        checksum,
`endif
    output logic [ADDR_W-1:0] words_written
);

    // One extra bit so MEM_BYTES == 2**ADDR_W does not alias to zero.
    localparam logic [ADDR_W:0]   MemEnd      = (ADDR_W + 1)'(MEM_BYTES);
    localparam logic [ADDR_W:0]   WordStep    = (ADDR_W + 1)'(BYTES_PER_WORD);
    localparam logic [ADDR_W-1:0] BaseAddr    = ADDR_W'(BASE_ADDR);
    localparam logic [1:0]        LastByteIdx = 2'(BYTES_PER_WORD - 1);

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic              last_q;
    logic              accept;
    logic              advance;
    logic              last_byte;
    logic              start_ok;
    logic [1:0]        byte_idx;
    logic [ADDR_W:0]   next_addr;

    always_comb begin
        word_ready = (state == StWaitWord);
        busy       = (state == StWaitWord) || (state == StWrite);
        start_ok   = ((state == StIdle) || (state == StDone)) && start;
        accept     = word_ready && word_valid;
        last_byte  = (byte_idx == LastByteIdx);
        advance    = (state == StWrite) && !last_byte;
        next_addr  = {1'b0, addr} + WordStep;
    end

    meminstruc_byte_serializer u_serializer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .advance   (advance),
        .word      (word_in),
        .byte_data (wr_data),
        .byte_idx  (byte_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= StIdle;
            addr          <= '0;
            last_q        <= 1'b0;
            wr_en         <= 1'b0;
            wr_addr       <= '0;
            done          <= 1'b0;
            overflow      <= 1'b0;
            words_written <= '0;
        end else begin
            unique case (state)
                StIdle, StDone: begin
                    if (start) begin
                        state         <= StWaitWord;
                        addr          <= BaseAddr;
                        words_written <= '0;
                        done          <= 1'b0;
                        overflow      <= 1'b0;
                    end
                end
                StWaitWord: begin
                    if (word_valid) begin
                        state   <= StWrite;
                        last_q  <= word_last;
                        wr_en   <= 1'b1;
                        wr_addr <= addr;
                    end
                end
                StWrite: begin
                    if (last_byte) begin
                        wr_en         <= 1'b0;
                        addr          <= next_addr[ADDR_W-1:0];
                        words_written <= words_written + ADDR_W'(1);
                        if (last_q) begin
                            state <= StDone;
                            done  <= 1'b1;
                        end else if (next_addr == MemEnd) begin
                            state    <= StDone;
                            done     <= 1'b1;
                            overflow <= 1'b1;
                        end else begin
                            state <= StWaitWord;
                        end
                    end else begin
                        wr_addr <= wr_addr + ADDR_W'(1);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef MEMINSTRUC_LOADER_CHECKSUM_EN
    logic [7:0] csum;

    // Accumulates each byte during its write cycle, so the total is complete
    // on the same edge that raises done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= '0;
        end else if (start_ok) begin
            csum <= '0;
        end else if (wr_en) begin
            csum <= csum + wr_data;
        end
    end

    assign checksum = csum;
`endif

endmodule

// File: tb/tb_meminstruc_loader.sv
module tb_meminstruc_loader;

    localparam int NV   = 6;
    localparam int MAXW = 20;

    typedef struct {
        int          sess;
        logic [31:0] word;
        logic        last;
        logic [7:0]  b0, b1, b2, b3;
        int          base;
        int          exp_ww;
    } vec_t;

    vec_t vecs [NV];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] word_in = '0;
    logic        word_valid = 1'b0;
    logic        word_last = 1'b0;
    logic        word_ready, wr_en, busy, done, overflow;
    logic [7:0]  wr_addr, wr_data, words_written;

    logic        o_start = 1'b0;
    logic [31:0] o_word_in = '0;
    logic        o_valid = 1'b0;
    logic        o_last = 1'b0;
    logic        o_ready, o_wr_en, o_busy, o_done, o_overflow;
    logic [3:0]  o_wr_addr, o_ww;
    logic [7:0]  o_wr_data;
`ifdef MEMINSTRUC_LOADER_CHECKSUM_EN
    logic [7:0]  checksum, o_checksum;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int         log_addr [$];
    logic [7:0] log_data [$];
    int         log_cyc  [$];
    int         o_log_addr [$];

    always #5 clk = ~clk;

    meminstruc_loader u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .word_in       (word_in),
        .word_valid    (word_valid),
        .word_last     (word_last),
        .word_ready    (word_ready),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .busy          (busy),
        .done          (done),
        .overflow      (overflow),
`ifdef MEMINSTRUC_LOADER_CHECKSUM_EN
        .checksum      (checksum),
`endif
        .words_written (words_written)
    );

    meminstruc_loader #(
        .MEM_BYTES (16),
        .ADDR_W    (4),
        .BASE_ADDR (0)
    ) u_ovf (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (o_start),
        .word_in       (o_word_in),
        .word_valid    (o_valid),
        .word_last     (o_last),
        .word_ready    (o_ready),
        .wr_en         (o_wr_en),
        .wr_addr       (o_wr_addr),
        .wr_data       (o_wr_data),
        .busy          (o_busy),
        .done          (o_done),
        .overflow      (o_overflow),
`ifdef MEMINSTRUC_LOADER_CHECKSUM_EN
        .checksum      (o_checksum),
`endif
        .words_written (o_ww)
    );

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (wr_en) begin
            log_addr.push_back(int'(wr_addr));
            log_data.push_back(wr_data);
            log_cyc.push_back(cyc);
        end
        if (o_wr_en) o_log_addr.push_back(int'(o_wr_addr));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input int sess, input logic [31:0] w, input logic l,
                           input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input int base, input int exp_ww);
        vecs[i].sess = sess;  vecs[i].word = w;  vecs[i].last = l;
        vecs[i].b0 = b0;  vecs[i].b1 = b1;  vecs[i].b2 = b2;  vecs[i].b3 = b3;
        vecs[i].base = base;  vecs[i].exp_ww = exp_ww;
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send_word(input logic [31:0] w, input logic l, output int low);
        low = 0;
        word_in = w;
        word_last = l;
        word_valid = 1'b1;
        while (!word_ready && low < MAXW) begin
            @(negedge clk);
            low++;
        end
        if (!word_ready) check("accept_timeout", 64'(word_ready), 64'd1);
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < MAXW) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(done), 64'd1);
    endtask

    initial begin
        int low, first, idx, prev_sess, n_log, acc, ready_seen, addr_bad;
        logic [7:0] eb [4];
        logic acc_now;
        logic [31:0] ovf_words [5];

        set_vec(0, 0, 32'h20080005, 1'b1, 8'h20, 8'h08, 8'h00, 8'h05, 0, 1);
        set_vec(1, 1, 32'h11223344, 1'b0, 8'h11, 8'h22, 8'h33, 8'h44, 0, 3);
        set_vec(2, 1, 32'h55667788, 1'b0, 8'h55, 8'h66, 8'h77, 8'h88, 4, 3);
        set_vec(3, 1, 32'h99AABBCC, 1'b1, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8, 3);
        set_vec(4, 2, 32'h01020304, 1'b0, 8'h01, 8'h02, 8'h03, 8'h04, 0, 2);
        set_vec(5, 2, 32'hFF000001, 1'b1, 8'hFF, 8'h00, 8'h00, 8'h01, 4, 2);
        ovf_words[0] = 32'hA0A1A2A3;  ovf_words[1] = 32'hB0B1B2B3;
        ovf_words[2] = 32'hC0C1C2C3;  ovf_words[3] = 32'hD0D1D2D3;
        ovf_words[4] = 32'hE0E1E2E3;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_word_ready", 64'(word_ready), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_words_written", 64'(words_written), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);

        // Table-driven sessions
        first = 0;
        prev_sess = -1;
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].sess != prev_sess) begin
                log_addr.delete();
                log_data.delete();
                log_cyc.delete();
                pulse_start();
                check("start_busy", 64'(busy), 64'd1);
                first = i;
                prev_sess = vecs[i].sess;
            end
            send_word(vecs[i].word, vecs[i].last, low);
            if (i != first) check($sformatf("ready_gap[%0d]", i), 64'(low), 64'd4);
            if (vecs[i].last) begin
                word_valid = 1'b0;
                wait_done($sformatf("done[s%0d]", vecs[i].sess));
                check($sformatf("ww[s%0d]", vecs[i].sess), 64'(words_written),
                      64'(vecs[i].exp_ww));
                check($sformatf("ovf[s%0d]", vecs[i].sess), 64'(overflow), 64'd0);
                check($sformatf("busy_end[s%0d]", vecs[i].sess), 64'(busy), 64'd0);
                check($sformatf("nbytes[s%0d]", vecs[i].sess), 64'(log_addr.size()),
                      64'(4 * (i - first + 1)));
                if (log_addr.size() == 4 * (i - first + 1)) begin
                    for (int j = first; j <= i; j++) begin
                        eb[0] = vecs[j].b0;  eb[1] = vecs[j].b1;
                        eb[2] = vecs[j].b2;  eb[3] = vecs[j].b3;
                        for (int k = 0; k < 4; k++) begin
                            idx = (j - first) * 4 + k;
                            check($sformatf("addr[v%0d b%0d]", j, k), 64'(log_addr[idx]),
                                  64'(vecs[j].base + k));
                            check($sformatf("data[v%0d b%0d]", j, k), 64'(log_data[idx]),
                                  64'(eb[k]));
                            if (k > 0)
                                check($sformatf("consec[v%0d b%0d]", j, k),
                                      64'(log_cyc[idx]), 64'(log_cyc[idx - 1] + 1));
                        end
                    end
                end
`ifdef MEMINSTRUC_LOADER_CHECKSUM_EN
                if (vecs[i].sess == 2) check("checksum", 64'(checksum), 64'h0A);
`endif
            end
        end

        // start during WRITE is ignored; start in DONE restarts at base
        log_addr.delete();
        log_data.delete();
        log_cyc.delete();
        pulse_start();
        send_word(32'hCAFEF00D, 1'b0, low);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_in_write_busy", 64'(busy), 64'd1);
        check("start_in_write_wr_en", 64'(wr_en), 64'd1);
        send_word(32'h0BADBEEF, 1'b1, low);
        word_valid = 1'b0;
        wait_done("done_after_ignored_start");
        check("ww_after_ignored_start", 64'(words_written), 64'd2);
        check("nbytes_ignored_start", 64'(log_addr.size()), 64'd8);
        if (log_addr.size() >= 8) check("addr4_ignored_start", 64'(log_addr[4]), 64'd4);
        pulse_start();
        check("restart_done", 64'(done), 64'd0);
        check("restart_ww", 64'(words_written), 64'd0);
        check("restart_busy", 64'(busy), 64'd1);
        send_word(32'h12345678, 1'b1, low);
        word_valid = 1'b0;
        wait_done("restart_done_end");
        check("restart_ww_end", 64'(words_written), 64'd1);
        if (log_addr.size() >= 9) check("restart_addr", 64'(log_addr[8]), 64'd0);
        else check("restart_nbytes", 64'(log_addr.size()), 64'd12);

        // Asynchronous reset during byte 2
        pulse_start();
        send_word(32'hDEADBEEF, 1'b1, low);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_addr", 64'(wr_addr), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_wr_en", 64'(wr_en), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_word_ready", 64'(word_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n_log = log_addr.size();
        repeat (8) @(negedge clk);
        check("post_rst_no_writes", 64'(log_addr.size()), 64'(n_log));
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_ready", 64'(word_ready), 64'd0);
        check("post_rst_done", 64'(done), 64'd0);
        word_valid = 1'b0;

        // Overflow: 16-byte memory, five words without last
        o_start = 1'b1;
        @(negedge clk);
        o_start = 1'b0;
        acc = 0;
        o_valid = 1'b1;
        for (int c = 0; c < 80; c++) begin
            o_word_in = ovf_words[(acc < 5) ? acc : 4];
            acc_now = o_ready;
            @(negedge clk);
            if (acc_now) acc++;
            if (o_done) break;
        end
        ready_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (o_ready) ready_seen++;
        end
        check("ovf_accepted", 64'(acc), 64'd4);
        check("ovf_done", 64'(o_done), 64'd1);
        check("ovf_overflow", 64'(o_overflow), 64'd1);
        check("ovf_ww", 64'(o_ww), 64'd4);
        check("ovf_busy", 64'(o_busy), 64'd0);
        check("ovf_5th_not_ready", 64'(ready_seen), 64'd0);
        check("ovf_nbytes", 64'(o_log_addr.size()), 64'd16);
        addr_bad = 0;
        foreach (o_log_addr[i]) if (o_log_addr[i] != i) addr_bad++;
        check("ovf_addr_order", 64'(addr_bad), 64'd0);
        o_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
